// File: rtl/muldiv_seq16.sv
// Sequential unsigned multiply/divide unit (MULTU/DIVU) for the MIPS datapath.
// A single shared adder/subtractor is stepped over WIDTH iterations, producing HI/LO.
module muldiv_seq16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | iterating, one step per cycle
    // FIN   | one cycle, done=1, hi/lo just written
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH:0]   work;
    logic [2*WIDTH:0]   work_nxt;
    logic [2*WIDTH:0]   work_sh;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic               add_sub;
    logic [WIDTH+1:0]   add_sum;

    // Shared adder: sub mode inverts y and injects carry-in of 1; carry-out is add_sum[WIDTH+1].
    always_comb begin
        add_sum = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
                + {{(WIDTH + 1){1'b0}}, add_sub};
    end

    // work holds {carry, hi_work, lo_work} for MULTU and {R, Q} for DIVU.
    always_comb begin
        work_sh  = '0;
        add_x    = '0;
        add_y    = {1'b0, m_q};
        add_sub  = op_q;
        work_nxt = work;
        if (!op_q) begin
            add_x = {1'b0, work[2*WIDTH-1:WIDTH]};
            if (work[0])
                work_nxt = {1'b0, add_sum[WIDTH:0], work[WIDTH-1:1]};
            else
                work_nxt = {1'b0, work[2*WIDTH:1]};
        end else begin
            work_sh = {work[2*WIDTH-1:0], 1'b0};
            add_x   = work_sh[2*WIDTH:WIDTH];
            if (add_sum[WIDTH+1])
                work_nxt = {add_sum[WIDTH:0], work_sh[WIDTH-1:1], 1'b1};
            else
                work_nxt = work_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= 1'b0;
            m_q         <= '0;
            work        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (state == FIN)
                        state <= IDLE;
                    if (start) begin
                        op_q        <= op;
                        m_q         <= op ? b : a;
                        cnt         <= CW'(WIDTH);
                        div_by_zero <= 1'b0;
                        work        <= {{(WIDTH + 1){1'b0}}, (op ? a : b)};
                        if (op && (b == '0)) begin
                            // Divide by zero skips iteration entirely.
                            state       <= FIN;
                            done        <= 1'b1;
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    work <= work_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= work_nxt[2*WIDTH-1:WIDTH];
                        lo    <= work_nxt[WIDTH-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq16.sv
// Self-checking bench for muldiv_seq16: vector table plus scoreboard queue,
// with hand-written sequences for ignored start, back-to-back start and reset abort.
module tb_muldiv_seq16;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start, op;
    logic [W-1:0] a, b, hi, lo;
    logic         busy, done, div_by_zero;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;
    logic [2*W:0] sb[$];

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } vec_t;
    vec_t vecs[8];

    muldiv_seq16 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        if (!o) begin
            p = (2*W)'(x) * (2*W)'(y);
            return {1'b0, p};
        end
        if (y == '0)
            return {1'b1, x, {W{1'b1}}};
        return {1'b0, x % y, x / y};
    endfunction

    // Called at the negedge of the acceptance cycle; returns at the negedge of the done cycle.
    task automatic wait_done(input string nm, input int exp_lat, input int inj);
        int           lat;
        int           bcnt;
        logic [2*W:0] e;
        lat  = 0;
        bcnt = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (c == inj) begin
                start = 1'b1; op = 1'b0; a = 16'd9; b = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
            end else begin
                if (busy) bcnt++;
                if (c == 1) begin
                    check({nm, "_dbz_clear"}, 32'(div_by_zero), 32'd0);
                    check({nm, "_hilo_hold"}, {hi, lo}, {prev_hi, prev_lo});
                end
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 40 cycles", nm);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: done with empty queue", nm);
            return;
        end
        e = sb.pop_front();
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat - 1));
        check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        check({nm, "_hi"}, 32'(hi), 32'(e[2*W-1:W]));
        check({nm, "_lo"}, 32'(lo), 32'(e[W-1:0]));
        check({nm, "_dbz"}, 32'(div_by_zero), 32'(e[2*W]));
        prev_hi = e[2*W-1:W];
        prev_lo = e[W-1:0];
    endtask

    task automatic run_op(input string nm, input logic o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [2*W:0] e, input int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        sb.push_back(e);
        wait_done(nm, lat, 0);
        @(negedge clk);
        check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
        check({nm, "_dbz_held"}, 32'(div_by_zero), 32'(e[2*W]));
    endtask

    initial begin
        int n_done;
        logic         ro;
        logic [W-1:0] rx, ry;

        vecs[0] = '{1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17};
        vecs[2] = '{1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[3] = '{1'b1, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0, 17};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17};
        vecs[5] = '{1'b1, 16'd3,    16'd5,    16'h0003, 16'h0000, 1'b0, 17};
        vecs[6] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1};
        vecs[7] = '{1'b0, 16'd2,    16'd3,    16'h0000, 16'h0006, 1'b0, 17};

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hilo", {hi, lo}, 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].dbz, vecs[i].hi, vecs[i].lo}, vecs[i].lat);

        for (int i = 0; i < 6; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = W'($urandom);
            ry = (i == 5) ? W'($urandom_range(1, 15)) : W'($urandom);
            run_op($sformatf("rnd%0d", i), ro, rx, ry, model(ro, rx, ry),
                   (ro && ry == '0) ? 1 : 17);
        end

        // Start during RUN is ignored; start held in FIN is accepted immediately.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'd3; b = 16'd4;
        sb.push_back({1'b0, 16'h0000, 16'h000C});
        wait_done("ignored_start", 17, 5);
        start = 1'b1; op = 1'b0; a = 16'd5; b = 16'd7;
        sb.push_back(model(1'b0, 16'd5, 16'd7));
        wait_done("fin_start", 17, 0);
        @(negedge clk);
        check("fin_start_done_one_cycle", 32'(done), 32'd0);

        // Reset in cycle 8 of a DIVU aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 16'd100; b = 16'd7;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 8) reset = 1'b1;
        end
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hilo", {hi, lo}, 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b0;
        prev_hi = '0;
        prev_lo = '0;
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // Reset wins over start in the same cycle.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 1'b0; a = 16'd1; b = 16'd1;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_idle_busy", 32'(busy), 32'd0);
        check("rst_start_idle_done", 32'(done), 32'd0);

        run_op("post_reset", 1'b1, 16'd1000, 16'd33, model(1'b1, 16'd1000, 16'd33), 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq16.md
Name: muldiv_seq16

Overview:
- Multi-cycle unsigned multiply/divide unit for the MIPS datapath. It implements MULTU and DIVU into HI/LO registers.
- It sequences one internal WIDTH-bit adder/subtractor over WIDTH iterations. The adder uses the same convention as the ALU: the sub-select inverts b, and carry-in = 1.
- Sits beside the main ALU. The control unit starts it, and the HI/LO outputs feed MFHI/MFLO.

Parameters:
WIDTH, 16, operand width; hi/lo width; iteration count.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; accepted only when busy=0.
op  input  1  0 = MULTU, 1 = DIVU; sampled with start.
a  input  WIDTH  multiplicand / dividend; sampled with start.
b  input  WIDTH  multiplier / divisor; sampled with start.
busy  output  1  high while iterating.
done  output  1  one-cycle pulse when hi/lo are updated.
hi  output  WIDTH  MULTU: product[2W-1:W]; DIVU: remainder.
lo  output  WIDTH  MULTU: product[W-1:0]; DIVU: quotient.
div_by_zero  output  1  set with done if DIVU had b=0; held until next acceptance.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: busy=0, done=0, hi=0, lo=0, div_by_zero=0, state=IDLE, iteration counter=0.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - FIN: one cycle; done=1.
- Acceptance: start=1 with busy=0 (IDLE or FIN) at edge E.
  - At E, latch op, a, b; counter loads WIDTH; clear div_by_zero.
  - Go to RUN, so busy=1 from E.
- start while busy=1 is ignored. Nothing is queued and latched operands are unaffected.
- RUN performs one iteration per cycle and the counter decrements. After WIDTH iterations (WIDTH cycles with busy=1):
  - write hi/lo;
  - go to FIN (busy=0, done=1 for exactly one cycle);
  - then go to IDLE unless a new start is accepted in FIN.
- Latency: start accepted at edge 0, busy=1 in cycles 1..WIDTH, done=1 with valid hi/lo in cycle WIDTH+1.
- MULTU (shift-add): 2W+1-bit accumulator {carry, hi_work, lo_work}, with lo_work initialised to the multiplier b.
  - Each iteration: if lo_work[0]=1, hi_work = hi_work + a (carry kept).
  - Then shift the whole accumulator right by 1.
  - Result is the full unsigned 2W-bit product; it cannot overflow.
- DIVU (restoring): remainder register R (W+1 bits) starts at 0, and Q starts at a.
  - Each iteration: shift {R,Q} left by 1, then trial = R - b via the adder in sub mode.
  - If there is no borrow (carry-out=1): R = trial and Q[0] = 1. Otherwise R is restored and Q[0] = 0.
  - Final result: lo = Q, hi = R[W-1:0].
- Divide by zero (op=1, b=0 at acceptance):
  - No iterations; go straight to FIN on the next edge, so done=1 in cycle 1.
  - Result: hi = a, lo = all ones, div_by_zero=1.
- hi/lo are written only on entry to FIN; they hold their previous values during RUN. Working registers are internal only.
- Reset during RUN or FIN aborts the operation: the next cycle has busy=0 and all outputs at reset values, and no done is issued.
- reset has priority over start in the same cycle.

Test Plan:
- MULTU a=0x1234, b=0x0010, start at cycle 0 -> busy=1 in cycles 1..16; cycle 17: done=1, hi=0x0001, lo=0x2340, div_by_zero=0; done=0 in cycle 18.
- MULTU a=0xFFFF, b=0xFFFF -> hi=0xFFFE, lo=0x0001; a=0, b=0xABCD -> hi=0, lo=0.
- DIVU a=100, b=7 -> lo=0x000E, hi=0x0002 at cycle 17. DIVU a=0xFFFF, b=0x0001 -> lo=0xFFFF, hi=0. DIVU a=3, b=5 -> lo=0, hi=3.
- DIVU a=0x1234, b=0 -> done=1 in cycle 1, busy never 1, hi=0x1234, lo=0xFFFF, div_by_zero=1. A following MULTU 2x3 clears div_by_zero at acceptance and ends with hi=0, lo=6.
- start pulsed with a=9, b=9 in cycle 5 of a running MULTU 3x4 -> ignored; result hi=0, lo=0x000C. start held in the FIN cycle -> accepted, with busy=1 the next cycle.
- reset asserted in cycle 8 of a DIVU -> cycle 9: busy=0, done=0, hi=0, lo=0; no done pulse follows. reset and start both high in one cycle -> stays IDLE.
